dma_bus_master: RTL and testbench

// - Initiator side of the 32-bit single-port memory bus (mem_wr / mem_addr / shared mem_data).
// - Copies count words from src_addr to dst_addr in bursts: reads up to BURST words into a local buffer, then writes them back.
// - Sits between the DMA register/control front end and the memory. It is the only bus initiator while busy.

---
 rtl/dma_pkg.sv | 24 ++
 rtl/dma_word_buffer.sv | 36 +++
 rtl/dma_bus_master.sv | 202 ++++++++++++++++++++
 tb/tb_dma_bus_master.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_pkg
// Brief    : Shared widths, reserved status address and FSM state encoding
// Revision : 1.0
// ============================================================================
package dma_pkg;

    localparam int DMA_DW        = 32;
    localparam int DMA_AW        = 8;
    localparam int DMA_RSVD_ADDR = 191;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_RD       = 3'd2,
        ST_RD_DRAIN = 3'd3,
        ST_WR       = 3'd4,
        ST_FIN      = 3'd5,
        ST_ERR      = 3'd6
    } dma_state_e;

endpackage
`default_nettype wire

// File: rtl/dma_word_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dma_word_buffer
// Brief    : BURST x DW burst buffer, clocked write port, async read port
// Revision : 1.0
// ============================================================================
module dma_word_buffer #(
    parameter int DW    = 32,
    parameter int BURST = 4,
    parameter int IW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [IW-1:0] wr_idx_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [IW-1:0] rd_idx_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [BURST];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BURST; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/dma_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : dma_bus_master
// Brief    : Burst copy engine driving the shared-data single-port memory bus
// Revision : 1.0
// ============================================================================
module dma_bus_master
    import dma_pkg::*;
#(
    parameter int DW        = DMA_DW,
    parameter int AW        = DMA_AW,
    parameter int BURST     = 4,
    parameter int RD_LAT    = 1,
    parameter int RSVD_ADDR = DMA_RSVD_ADDR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] count,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          memfull,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    inout  wire  [DW-1:0] mem_data
);

    localparam int            IW       = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int            LW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [AW:0]   ADDR_MAX = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0]   RSVD     = (AW+1)'(RSVD_ADDR);
    localparam logic [AW:0]   ONE_X    = (AW+1)'(1);
    localparam logic [AW-1:0] BURST_A  = AW'(BURST);
    localparam logic [AW-1:0] ONE_A    = AW'(1);
    localparam logic [IW-1:0] ONE_I    = IW'(1);
    localparam logic [LW-1:0] ONE_L    = LW'(1);

    dma_state_e    state_q;
    logic          busy_q, done_q, err_q, mem_wr_q;
    logic [AW-1:0] mem_addr_q, src_q, dst_q, rem_q;
    logic [IW-1:0] idx_q, n_last_q;
    logic [LW-1:0] drain_q;
    logic [RD_LAT-1:0] pipe_vld_q;
    logic [IW-1:0]     pipe_idx_q [RD_LAT];

    logic [AW-1:0] w_n, w_src_d, w_dst_d, w_rem_d;
    logic [AW:0]   w_src_end, w_dst_end;
    logic          w_cnt_nz, w_ovf, w_rsvd, w_ovl, w_reject;
    logic [DW-1:0] w_wr_data;

    // Last slot index of a burst: min(BURST, r) - 1.
    function automatic logic [IW-1:0] burst_last(input logic [AW-1:0] r);
        return (r >= BURST_A) ? IW'(BURST - 1) : IW'(r - ONE_A);
    endfunction

    assign w_n     = AW'(n_last_q) + ONE_A;
    assign w_src_d = src_q + w_n;
    assign w_dst_d = dst_q + w_n;
    assign w_rem_d = rem_q - w_n;

    // Range checks use one extra bit so end addresses past the top cannot wrap.
    assign w_cnt_nz  = (rem_q != '0);
    assign w_src_end = {1'b0, src_q} + {1'b0, rem_q} - ONE_X;
    assign w_dst_end = {1'b0, dst_q} + {1'b0, rem_q} - ONE_X;
    assign w_ovf     = w_cnt_nz && ((w_src_end > ADDR_MAX) || (w_dst_end > ADDR_MAX));
    assign w_rsvd    = w_cnt_nz && ((({1'b0, src_q} <= RSVD) && (w_src_end >= RSVD)) ||
                                    (({1'b0, dst_q} <= RSVD) && (w_dst_end >= RSVD)));
    assign w_ovl     = (dst_q > src_q) && ({1'b0, dst_q} < ({1'b0, src_q} + {1'b0, rem_q}));
    assign w_reject  = w_ovf || w_rsvd || w_ovl || memfull;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            idx_q      <= '0;
            n_last_q   <= '0;
            drain_q    <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_idx_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            // Capture pipeline: slot index of each issued read, aged RD_LAT cycles.
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
            end
            pipe_vld_q[0] <= (state_q == ST_RD);
            pipe_idx_q[0] <= idx_q;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        rem_q   <= count;
                        busy_q  <= 1'b1;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_reject) begin
                        err_q   <= 1'b1;
                        state_q <= ST_ERR;
                    end else if (!w_cnt_nz) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        mem_addr_q <= src_q;
                        idx_q      <= '0;
                        n_last_q   <= burst_last(rem_q);
                        state_q    <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (idx_q == n_last_q) begin
                        drain_q <= LW'(RD_LAT - 1);
                        state_q <= ST_RD_DRAIN;
                    end else begin
                        idx_q      <= idx_q + ONE_I;
                        mem_addr_q <= mem_addr_q + ONE_A;
                    end
                end
                ST_RD_DRAIN: begin
                    if (drain_q == '0) begin
                        mem_wr_q   <= 1'b1;
                        mem_addr_q <= dst_q;
                        idx_q      <= '0;
                        state_q    <= ST_WR;
                    end else begin
                        drain_q <= drain_q - ONE_L;
                    end
                end
                ST_WR: begin
                    if (idx_q == n_last_q) begin
                        mem_wr_q <= 1'b0;
                        src_q    <= w_src_d;
                        dst_q    <= w_dst_d;
                        rem_q    <= w_rem_d;
                        if (w_rem_d != '0) begin
                            mem_addr_q <= w_src_d;
                            idx_q      <= '0;
                            n_last_q   <= burst_last(w_rem_d);
                            state_q    <= ST_RD;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end
                    end else begin
                        idx_q      <= idx_q + ONE_I;
                        mem_addr_q <= mem_addr_q + ONE_A;
                    end
                end
                ST_FIN, ST_ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q   <= 1'b0;
                    mem_wr_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    dma_word_buffer #(
        .DW    (DW),
        .BURST (BURST),
        .IW    (IW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (pipe_vld_q[RD_LAT-1]),
        .wr_idx_i  (pipe_idx_q[RD_LAT-1]),
        .wr_data_i (mem_data),
        .rd_idx_i  (idx_q),
        .rd_data_o (w_wr_data)
    );

    assign mem_data = mem_wr_q ? w_wr_data : {DW{1'bz}};
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign mem_wr   = mem_wr_q;
    assign mem_addr = mem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_bus_master
// Brief    : Transfer table against an RD_LAT=1 memory responder, write-beat scoreboard
// Revision : 1.0
// ============================================================================
module tb_dma_bus_master;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          memfull = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW-1:0] count = '0;
    logic          busy, done, err, mem_wr;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dma_bus_master #(.DW(DW), .AW(AW), .BURST(4), .RD_LAT(1), .RSVD_ADDR(191)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .memfull  (memfull),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

    // Responder: registered read one cycle after the address, drives only on read cycles.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rdata_q = '0;
    logic          rd_pend_q = 1'b0;
    logic          preloaded = 1'b0;

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= DW'(i + 100);
            preloaded <= 1'b1;
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_data;
        end
        rdata_q   <= mem[mem_addr];
        rd_pend_q <= busy && !mem_wr;
    end

    assign mem_data = (rd_pend_q && !mem_wr) ? rdata_q : {DW{1'bz}};

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        logic [7:0] src;
        logic [7:0] dst;
        logic [7:0] cnt;
        bit         full;
        bit         late_full;
        bit         repulse;
        bit         exp_err;
        int         exp_cyc;
    } vec_t;

    beat_t         exp_q[$];
    beat_t         e;
    logic [DW-1:0] ref_mem [256];
    int            wr_beats = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Bus monitor and write-beat scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if ($isunknown(mem_data) && (mem_data !== {DW{1'bz}})) begin
                bad++;
                $display("FAIL bus_x: mem_data=%h required no X", mem_data);
            end
            if (mem_wr) begin
                wr_beats++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL wr_unexpected: addr=%0d data=%0d required no write", mem_addr, mem_data);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_addr !== e.addr || mem_data !== e.data) begin
                        bad++;
                        $display("FAIL wr_beat: addr=%0d data=%0d required addr=%0d data=%0d",
                                 mem_addr, mem_data, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic run_vec(input int id, input vec_t v);
        int         cyc, ndone, nerr, done_at, beats0, mism;
        logic [7:0] a;
        if (!v.exp_err) begin
            for (int i = 0; i < int'(v.cnt); i++) begin
                exp_q.push_back('{addr: AW'(v.dst + 8'(i)), data: ref_mem[8'(v.src + 8'(i))]});
                ref_mem[8'(v.dst + 8'(i))] = ref_mem[8'(v.src + 8'(i))];
            end
        end
        beats0 = wr_beats;
        @(negedge clk);
        start = 1'b1; src_addr = v.src; dst_addr = v.dst; count = v.cnt; memfull = v.full;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; ndone = 0; nerr = 0; done_at = -1;
        while (busy && cyc < 400) begin
            if (done) begin ndone++; done_at = cyc; end
            if (err) nerr++;
            if (cyc == 1) memfull = v.late_full;
            if (v.repulse && cyc == 2) begin
                start = 1'b1; src_addr = 8'd0; dst_addr = 8'd220; count = 8'd3;
            end
            if (cyc == 3) start = 1'b0;
            cyc++;
            @(negedge clk);
        end
        memfull = 1'b0;
        start   = 1'b0;
        if (cyc >= 400) begin
            bad++; total++;
            $display("FAIL v%0d_timeout: busy still high after %0d cycles required done/err", id, cyc);
        end
        chk($sformatf("v%0d_busy_cycles", id), cyc, v.exp_cyc);
        chk($sformatf("v%0d_done_pulses", id), ndone, v.exp_err ? 0 : 1);
        chk($sformatf("v%0d_err_pulses", id), nerr, v.exp_err ? 1 : 0);
        chk($sformatf("v%0d_done_after_idle", id), int'(done), 0);
        chk($sformatf("v%0d_write_beats", id), wr_beats - beats0, v.exp_err ? 0 : int'(v.cnt));
        chk($sformatf("v%0d_beats_left", id), exp_q.size(), 0);
        exp_q.delete();
        if (!v.exp_err) begin
            chk($sformatf("v%0d_done_cycle", id), done_at, v.exp_cyc - 1);
            if (v.cnt != 8'd0)
                chk($sformatf("v%0d_addr_hold", id), int'(mem_addr), int'(8'(v.dst + v.cnt - 8'd1)));
        end
        mism = 0;
        for (int j = 0; j < int'(v.cnt); j++) begin
            a = v.dst + 8'(j);
            if (mem[a] !== ref_mem[a]) mism++;
        end
        chk($sformatf("v%0d_dst_words_wrong", id), mism, 0);
        chk($sformatf("v%0d_status_word", id), int'(mem[191]), 291);
    endtask

    vec_t vecs[12];

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) ref_mem[i] = DW'(i + 100);
        //             src    dst    cnt   full late rep  err  cycles
        vecs[0]  = '{8'd0,   8'd64,  8'd3,  0, 0, 0, 0,   9};
        vecs[1]  = '{8'd10,  8'd100, 8'd9,  0, 1, 0, 0,  23};
        vecs[2]  = '{8'd5,   8'd40,  8'd0,  0, 0, 0, 0,   2};
        vecs[3]  = '{8'd0,   8'd188, 8'd5,  0, 0, 0, 1,   2};
        vecs[4]  = '{8'd250, 8'd0,   8'd10, 0, 0, 0, 1,   2};
        vecs[5]  = '{8'd20,  8'd22,  8'd5,  0, 0, 0, 1,   2};
        vecs[6]  = '{8'd0,   8'd64,  8'd3,  1, 0, 0, 1,   2};
        vecs[7]  = '{8'd30,  8'd120, 8'd6,  0, 0, 1, 0,  16};
        vecs[8]  = '{8'd200, 8'd150, 8'd1,  0, 0, 0, 0,   5};
        vecs[9]  = '{8'd40,  8'd36,  8'd8,  0, 0, 0, 0,  20};
        vecs[10] = '{8'd188, 8'd10,  8'd4,  0, 0, 0, 1,   2};
        vecs[11] = '{8'd192, 8'd0,   8'd64, 0, 0, 0, 0, 146};

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_mem_wr", int'(mem_wr), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Reset during the second write beat of a 4-word copy.
        exp_q.push_back('{addr: 8'd64, data: ref_mem[0]});
        ref_mem[64] = ref_mem[0];
        @(negedge clk);
        start = 1'b1; src_addr = 8'd0; dst_addr = 8'd64; count = 8'd4;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!mem_wr && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        chk("rstwr_first_beat_seen", int'(cyc < 50), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rstwr_mem_wr", int'(mem_wr), 0);
        chk("rstwr_busy", int'(busy), 0);
        chk("rstwr_done", int'(done), 0);
        @(negedge clk);
        chk("rstwr_beats_left", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("rstwr_busy_held", int'(busy), 0);
        chk("rstwr_second_word_untouched", int'(mem[65] === ref_mem[65]), 1);
        rst = 1'b0;
        @(negedge clk);
        run_vec(12, '{8'd0, 8'd64, 8'd4, 0, 0, 0, 0, 11});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
